// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write-back entry type and grant encoding for wb_arbiter.
package wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] reg_addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;
   typedef enum logic {GNT_REQ0 = 1'b0, GNT_REQ1 = 1'b1} gnt_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of wb_req_t; a DEPTH+1-state count separates full from empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;
   always_comb begin
      full     = cnt_q == CNT_W'(DEPTH);
      empty    = cnt_q == '0;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      head     = mem_q[rd_ptr_q];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of two write-back FIFOs into one register-file write port.
// Defining WB_SCOREBOARD_EN adds the per-register pending scoreboard.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [REG_ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0]     req0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [REG_ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0]     req1_data,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] Write_register,
   output logic [DATA_W-1:0]     Write_data,
   output logic [NUM_REGS-1:0]   pending
);
   wb_req_t               in0, in1, head0, head1, gnt_req;
   logic                  full0, full1, empty0, empty1;
   logic                  push0, push1, pop0, pop1, gnt;
   gnt_t                  last_q, last_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d;
   always_comb begin
      in0         = '{reg_addr: req0_reg, data: req0_data};
      in1         = '{reg_addr: req1_reg, data: req1_data};
      req0_ready  = !reset && !full0;
      req1_ready  = !reset && !full1;
      push0       = req0_valid && req0_ready;
      push1       = req1_valid && req1_ready;
      pop0        = !empty0 && (empty1 || last_q == GNT_REQ1);
      pop1        = !empty1 && (empty0 || last_q == GNT_REQ0);
      gnt         = pop0 || pop1;
      gnt_req     = pop0 ? head0 : head1;
      last_d      = pop0 ? GNT_REQ0 : pop1 ? GNT_REQ1 : last_q;
      // register 0 still burns its slot but never writes
      reg_write_d = gnt && gnt_req.reg_addr != '0;
      wr_reg_d    = gnt ? gnt_req.reg_addr : wr_reg_q;
      wr_data_d   = gnt ? gnt_req.data : wr_data_q;
      RegWrite       = reg_write_q;
      Write_register = wr_reg_q;
      Write_data     = wr_data_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q      <= GNT_REQ1;
         reg_write_q <= 1'b0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
      end else begin
         last_q      <= last_d;
         reg_write_q <= reg_write_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
      end
   end
   wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk      (clk),
      .reset    (reset),
      .push     (push0),
      .push_data(in0),
      .pop      (pop0),
      .head     (head0),
      .full     (full0),
      .empty    (empty0)
   );
   wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk      (clk),
      .reset    (reset),
      .push     (push1),
      .push_data(in1),
      .pop      (pop1),
      .head     (head1),
      .full     (full1),
      .empty    (empty1)
   );
`ifdef WB_SCOREBOARD_EN
   localparam int SB_W = $clog2(2 * DEPTH + 1);
   logic [SB_W-1:0] sb_cnt_q [NUM_REGS];
   logic [SB_W-1:0] sb_cnt_d [NUM_REGS];
   // per-register count of queued entries; the output stage is covered by the RegWrite term
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         sb_cnt_d[r] = sb_cnt_q[r]
                     + SB_W'(push0 && req0_reg == REG_ADDR_W'(r))
                     + SB_W'(push1 && req1_reg == REG_ADDR_W'(r))
                     - SB_W'(gnt && gnt_req.reg_addr == REG_ADDR_W'(r));
         pending[r]  = r != 0 && (sb_cnt_q[r] != '0 || (reg_write_q && wr_reg_q == REG_ADDR_W'(r)));
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) sb_cnt_q[r] <= '0;
      end else begin
         sb_cnt_q <= sb_cnt_d;
      end
   end
`else
   always_comb pending = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter (DEPTH=2); pending checks follow WB_SCOREBOARD_EN.
`timescale 1ns/1ps
module tb_wb_arbiter;
   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [4:0]  req0_reg = '0, req1_reg = '0;
   logic [31:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready, RegWrite;
   logic [4:0]  Write_register;
   logic [31:0] Write_data, pending;
   int          tests = 0, fails = 0, cyc = 0;
   ent_t        src0[$], src1[$], exp0[$], exp1[$];
   int          obs_reg[$], obs_cyc[$], acc1_at[$];
   logic        rdy1_log[$];

   wb_arbiter #(.DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_reg      (req0_reg),
      .req0_data     (req0_data),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_reg      (req1_reg),
      .req1_data     (req1_data),
      .RegWrite      (RegWrite),
      .Write_register(Write_register),
      .Write_data    (Write_data),
      .pending       (pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // every write must match the oldest outstanding entry of one requester
   always @(negedge clk) begin
      if (!reset && RegWrite) begin
         tests++;
         obs_reg.push_back(int'(Write_register));
         obs_cyc.push_back(cyc);
         if (exp0.size() > 0 && exp0[0] === {Write_register, Write_data}) void'(exp0.pop_front());
         else if (exp1.size() > 0 && exp1[0] === {Write_register, Write_data}) void'(exp1.pop_front());
         else begin
            fails++;
            $display("FAIL sb_write: got reg %0d data %h, required head of a requester queue", Write_register, Write_data);
         end
      end
   end

   task automatic drive(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         req0_valid = src0.size() > 0;
         req1_valid = src1.size() > 0;
         if (req0_valid) {req0_reg, req0_data} = src0[0];
         if (req1_valid) {req1_reg, req1_data} = src1[0];
         @(negedge clk);
         rdy1_log.push_back(req1_ready);
         if (req0_valid && req0_ready) begin
            if (req0_reg != 5'd0) exp0.push_back(src0[0]);
            void'(src0.pop_front());
         end
         if (req1_valid && req1_ready) begin
            if (req1_reg != 5'd0) exp1.push_back(src1[0]);
            void'(src1.pop_front());
            acc1_at.push_back(c);
         end
         @(posedge clk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp0.size() + exp1.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (exp0.size() + exp1.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries still outstanding, required 0", exp0.size() + exp1.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      exp0.delete();
      exp1.delete();
      src0.delete();
      src1.delete();
      @(negedge clk);
      tests += 6;
      if (RegWrite !== 1'b0) begin fails++; $display("FAIL rst_regwrite: got %b, required 0", RegWrite); end
      if (Write_register !== 5'd0) begin fails++; $display("FAIL rst_wreg: got %0d, required 0", Write_register); end
      if (Write_data !== 32'd0) begin fails++; $display("FAIL rst_wdata: got %h, required 0", Write_data); end
      if (pending !== 32'd0) begin fails++; $display("FAIL rst_pending: got %h, required 0", pending); end
      if (req0_ready !== 1'b0) begin fails++; $display("FAIL rst_ready0: got %b, required 0", req0_ready); end
      if (req1_ready !== 1'b0) begin fails++; $display("FAIL rst_ready1: got %b, required 0", req1_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests += 2;
      if (req0_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready0: got %b, required 1", req0_ready); end
      if (req1_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready1: got %b, required 1", req1_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      int order[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
      obs_reg.delete();
      obs_cyc.delete();
      for (int i = 1; i <= 4; i++) begin
         src0.push_back('{r: 5'(i), d: 32'hA000 + 32'(i)});
         src1.push_back('{r: 5'(10 + i), d: 32'hB000 + 32'(i)});
      end
      drive(12);
      drain();
      tests++;
      if (obs_reg.size() != 8) begin fails++; $display("FAIL cont_count: got %0d writes, required 8", obs_reg.size()); end
      for (int i = 0; i < 8 && i < obs_reg.size(); i++) begin
         tests += 2;
         if (obs_reg[i] != order[i]) begin fails++; $display("FAIL cont_order[%0d]: got reg %0d, required %0d", i, obs_reg[i], order[i]); end
         if (obs_cyc[i] != obs_cyc[0] + i) begin fails++; $display("FAIL cont_gap[%0d]: got cycle %0d, required %0d", i, obs_cyc[i], obs_cyc[0] + i); end
      end
   endtask

   task automatic test_full();
      acc1_at.delete();
      rdy1_log.delete();
      for (int i = 0; i < 6; i++) src0.push_back('{r: 5'(21 + i), d: 32'hC000 + 32'(i)});
      for (int i = 0; i < 3; i++) src1.push_back('{r: 5'(31 - i), d: 32'hD000 + 32'(i)});
      drive(10);
      drain();
      tests++;
      if (acc1_at.size() != 3) begin fails++; $display("FAIL full_accepts: got %0d, required 3", acc1_at.size()); end
      else begin
         tests += 2;
         if (rdy1_log[acc1_at[1] + 1] !== 1'b0) begin fails++; $display("FAIL full_ready: got %b after 2 accepts, required 0", rdy1_log[acc1_at[1] + 1]); end
         if (acc1_at[2] != acc1_at[1] + 2) begin fails++; $display("FAIL full_third: accepted at %0d, required %0d", acc1_at[2], acc1_at[1] + 2); end
      end
   endtask

   task automatic single_write(input logic [4:0] r, input logic [31:0] d);
      logic [31:0] pexp;
      pexp = (SB && r != 5'd0) ? (32'h1 << r) : 32'h0;
      req0_reg = r;
      req0_data = d;
      req0_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (req0_ready !== 1'b1) begin fails++; $display("FAIL sw_ready: got %b, required 1", req0_ready); end
      if (r != 5'd0) exp0.push_back('{r: r, d: d});
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      tests += 2;
      if (RegWrite !== 1'b0) begin fails++; $display("FAIL sw_early: got RegWrite %b one edge after accept, required 0", RegWrite); end
      if (pending !== pexp) begin fails++; $display("FAIL sw_pend_q: got %h, required %h", pending, pexp); end
      @(negedge clk);
      tests += 3;
      if (RegWrite !== (r != 5'd0)) begin fails++; $display("FAIL sw_regwrite: got %b, required %b", RegWrite, r != 5'd0); end
      if (Write_register !== r) begin fails++; $display("FAIL sw_wreg: got %0d, required %0d", Write_register, r); end
      if (pending !== pexp) begin fails++; $display("FAIL sw_pend_w: got %h, required %h", pending, pexp); end
      if (r != 5'd0) begin
         tests++;
         if (Write_data !== d) begin fails++; $display("FAIL sw_wdata: got %h, required %h", Write_data, d); end
      end
      @(negedge clk);
      tests += 3;
      if (RegWrite !== 1'b0) begin fails++; $display("FAIL sw_once: got RegWrite %b, required 0", RegWrite); end
      if (Write_register !== r) begin fails++; $display("FAIL sw_hold: got reg %0d, required %0d", Write_register, r); end
      if (pending !== 32'h0) begin fails++; $display("FAIL sw_pend_clr: got %h, required 0", pending); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      src0.push_back('{r: 5'd2, d: 32'hE002});
      src0.push_back('{r: 5'd3, d: 32'hE003});
      src1.push_back('{r: 5'd12, d: 32'hE012});
      src1.push_back('{r: 5'd13, d: 32'hE013});
      drive(2);
      test_reset();
      n = obs_reg.size();
      repeat (10) @(negedge clk);
      tests++;
      if (obs_reg.size() != n) begin fails++; $display("FAIL rst_flush: got %0d writes after reset, required 0", obs_reg.size() - n); end
   endtask

   initial begin
      #1;
      test_reset();
      test_contention();
      test_full();
      single_write(5'd5, 32'hDEADBEEF);
      single_write(5'd7, 32'h0BADF00D);
      single_write(5'd0, 32'h00001234);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, required completion before 100000ns");
      $fatal(1);
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-requester FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has a write-back entry.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  FIFO can accept the entry this cycle.
REQ-006 SHALL have ports req0_reg / req1_reg  input  5  destination register number.
REQ-007 SHALL have ports req0_data / req1_data  input  32  write-back value.
REQ-008 SHALL have port RegWrite  output  1  register-file write enable, one cycle per grant.
REQ-009 SHALL have port Write_register  output  5  register-file write address.
REQ-010 SHALL have port Write_data  output  32  register-file write data.
REQ-011 SHALL have port pending  output  32  per-register queued-write mask.

Function
REQ-012 SHALL transfer an entry when reqN_valid and reqN_ready are both high at a rising edge.
REQ-013 SHALL drive reqN_ready = FIFO N not full, independent of reqN_valid and of any same-cycle pop.
REQ-014 SHALL NOT accept a push into a full FIFO, even when that FIFO pops in the same cycle.
REQ-015 SHALL pop at most one FIFO head per cycle.
REQ-016 SHALL grant the only non-empty FIFO when one is non-empty, and the FIFO not granted last when both are non-empty.
REQ-017 SHALL keep a last-grant pointer that updates only on a grant.
REQ-018 SHALL register RegWrite, Write_register and Write_data. Entry accepted at edge E gives RegWrite high no earlier than the cycle after edge E+1.
REQ-019 SHALL hold RegWrite high for exactly one cycle per granted entry. When no grant occurs, RegWrite SHALL be 0 and Write_register/Write_data SHALL hold their values.
REQ-020 SHALL consume a grant slot for an entry whose register is 0, driving RegWrite=0 and Write_register=0 for that slot.
REQ-021 SHALL preserve FIFO order within a requester. No ordering is guaranteed between requesters.
REQ-022 SHALL sustain one write per cycle when both FIFOs hold entries. Each requester SHALL get at least every other grant.
REQ-023 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-024 SHALL use a count of DEPTH+1 states per FIFO to distinguish full from empty.

Reset
REQ-025 SHALL, on reset assertion at any time, immediately empty both FIFOs and discard in-flight entries.
REQ-026 SHALL set the following values while reset is asserted: RegWrite=0, Write_register=0, Write_data=0, pending=0, req0_ready=0, req1_ready=0.
REQ-027 SHALL set the last-grant pointer to requester 1, so req0 wins the first contended cycle.
REQ-028 SHALL assert reqN_ready in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with WB_SCOREBOARD_EN defined, set pending[r] (r≠0) while any FIFO entry or the output register with RegWrite=1 targets r. pending[0] SHALL be constant 0.
REQ-030 SHALL keep pending[r] set until the cycle after the RegWrite cycle for the last such entry.
REQ-031 SHALL, without WB_SCOREBOARD_EN, keep the pending port present and tie it to 32'h0, adding no scoreboard logic.

Structure
REQ-032 SHALL take REG_ADDR_W=5, DATA_W=32 and struct type wb_req_t {reg, data} from shared package wb_pkg.
REQ-033 SHALL instantiate sub-module wb_fifo (DEPTH entries of wb_req_t, push/pop/full/empty) once per requester.

Verification
REQ-034 Single write: req0 pushes (reg 5, 32'hDEADBEEF) -> exactly one RegWrite cycle with Write_register=5, Write_data=32'hDEADBEEF, 2 edges after acceptance.
REQ-035 Contention: both valid every cycle, req0 reg 1..4, req1 reg 11..14 -> grant order 1,11,2,12,3,13,4,14 with no idle cycles.
REQ-036 Full: DEPTH=2, req1 pushes 3 entries while req0 stream saturates grants -> req1_ready=0 after 2 accepted, third accepted only after the next cycle in which req1_ready=1.
REQ-037 Register 0: req0 pushes (reg 0, 32'h1234) -> grant slot consumed, RegWrite stays 0, and pending stays 0.
REQ-038 Reset mid-operation: 2 entries queued in each FIFO, reset pulsed -> no RegWrite ever for them, outputs 0 during reset, ready=1 the cycle after release.
REQ-039 Scoreboard (WB_SCOREBOARD_EN): push reg 7 -> pending[7]=1 from the cycle after acceptance until the cycle after RegWrite. Without the macro, pending stays 0.
